glove_tracker: RTL
==================

Name: glove_tracker

Overview:
- Upstream of the ball state machine; one instance per glove.
- Converts raw camera blob measurements (pixel centroid plus blob area) into the millimetre glove position, the closed flag and a tracking flag that the ball logic consumes.
- Pipeline stages: pixel-to-mm scaling with saturation, exponential smoothing, area-based open/closed detection with hysteresis and debounce, and loss-of-tracking timeout.

Parameters:
- SCALE_X, 640, mm per pixel in unsigned Q8.8 for x (2.5 mm/px)
- SCALE_Y, 640, same for y
- OFFSET_X, 0, mm added after scaling, x
- OFFSET_Y, 0, mm added after scaling, y
- ALPHA_SHIFT, 2, smoothing shift; new = old + ((target - old) >>> ALPHA_SHIFT)
- CLOSE_THRESH, 2000, area strictly below this counts as a closed vote
- OPEN_THRESH, 3000, area strictly above this counts as an open vote; must be > CLOSE_THRESH
- DEBOUNCE, 3, consecutive agreeing samples needed to change glove_closed (1..15)
- TIMEOUT, 2700000, clk cycles without meas_valid before tracking is lost (100 ms at 27 MHz); must be >= 4

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- meas_valid  in  1  one-cycle strobe; a new measurement is present; accepted every cycle, no backpressure
- meas_x  in  11  blob centroid x, pixels
- meas_y  in  10  blob centroid y, pixels
- meas_area  in  20  blob area, pixels
- glovex  out  16  smoothed x position, mm
- glovey  out  16  smoothed y position, mm
- glove_closed  out  1  debounced closed flag
- tracked  out  1  1 while measurements keep arriving
- pos_valid  out  1  one-cycle pulse when glovex/glovey/glove_closed update

Behaviour:
- Reset (reset low, asynchronous): glovex=0, glovey=0, glove_closed=0, tracked=0, pos_valid=0. All pipeline valids, debounce counters and the timeout counter clear. The first-sample flag is set.
- Stage 1 (cycle after meas_valid):
  - register prod_x = meas_x*SCALE_X (27-bit) and prod_y likewise.
  - register area and valid.
- Stage 2:
  - target = (prod >> 8) + OFFSET, computed 19-bit unsigned.
  - if > 65535, saturate to 65535.
  - compute area votes: closed_vote = area < CLOSE_THRESH; open_vote = area > OPEN_THRESH.
- Stage 3 (outputs):
  - if the first-sample flag is set, glovex/glovey load target directly and the flag clears.
  - otherwise diff = target - current, 17-bit signed; current += diff >>> ALPHA_SHIFT (arithmetic shift, truncation toward -inf). The result always stays in 0..65535.
  - pos_valid=1 for exactly this cycle.
  - tracked=1.
  - total latency meas_valid -> pos_valid is 3 cycles; back-to-back samples give back-to-back pulses.
- Debounce, updated at stage 3 per sample:
  - closed_cnt increments on closed_vote, else clears. open_cnt increments on open_vote, else clears.
  - a sample in the band CLOSE_THRESH..OPEN_THRESH inclusive clears both counters.
  - when closed_cnt reaches DEBOUNCE, glove_closed=1 on that same stage-3 cycle. open_cnt reaching DEBOUNCE sets glove_closed=0.
  - counters saturate at DEBOUNCE.
- Timeout:
  - counter clears on any meas_valid; otherwise it increments and saturates.
  - on reaching TIMEOUT: tracked=0, glove_closed=0 (a lost glove never holds the ball), debounce counters clear, first-sample flag set.
  - glovex/glovey hold their last value.
  - meas_valid on the expiry cycle wins: counter clears, no loss declared.
  - TIMEOUT >= 4 guarantees the pipeline is empty at expiry.
- No state outside the reset above depends on reset timing. Reset asserted mid-pipeline discards in-flight samples; no pos_valid is emitted for them.

Test Plan:
- Single sample, defaults, meas_x=100, meas_y=40, area=5000 after reset -> 3 cycles later pos_valid pulse, glovex=250, glovey=100, tracked=1, glove_closed=0.
- Smoothing: then meas_x=200 -> glovex=250+(250>>2)=312. Then meas_x=0 -> diff=-312, >>>2 = -78, glovex=234.
- Saturation, OFFSET_X=65000, meas_x=2047 -> target 70117 clamps; first-sample glovex=65535.
- Debounce, areas 1500,1500,2500,1500,1500,1500 -> glove_closed rises only with the 6th pos_valid. Then areas 3500 x3 -> falls on the 3rd.
- Timeout, TIMEOUT=50, closed glove, then no meas_valid -> at cycle 50 after the last strobe tracked=0, glove_closed=0, glovex held. The next sample x=100 loads glovex=250 directly.
- Reset mid-op: reset low one cycle after meas_valid -> outputs 0 immediately. No pos_valid follows. The next sample after release loads directly.

Source files
------------

// File: rtl/glove_tracker.sv
// Per-glove tracker: turns camera blob centroid/area into a smoothed mm position,
// a debounced closed flag and a tracking flag, through a 3-stage pipeline.
module glove_tracker #(
  parameter int unsigned SCALE_X      = 640,
  parameter int unsigned SCALE_Y      = 640,
  parameter int unsigned OFFSET_X     = 0,
  parameter int unsigned OFFSET_Y     = 0,
  parameter int unsigned ALPHA_SHIFT  = 2,
  parameter int unsigned CLOSE_THRESH = 2000,
  parameter int unsigned OPEN_THRESH  = 3000,
  parameter int unsigned DEBOUNCE     = 3,
  parameter int unsigned TIMEOUT      = 2700000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        meas_valid,
  input  logic [10:0] meas_x,
  input  logic [9:0]  meas_y,
  input  logic [19:0] meas_area,
  output logic [15:0] glovex,
  output logic [15:0] glovey,
  output logic        glove_closed,
  output logic        tracked,
  output logic        pos_valid
);

  localparam int unsigned PW    = 27;
  localparam int unsigned TW    = 19;
  localparam int unsigned AW    = 20;
  localparam int unsigned CW    = 4;
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  logic          s1_valid_q, s1_valid_d;
  logic [PW-1:0] prod_x_q, prod_x_d, prod_y_q, prod_y_d;
  logic [AW-1:0] area_q, area_d;

  logic          s2_valid_q, s2_valid_d;
  logic [15:0]   tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
  logic          closed_vote_q, closed_vote_d, open_vote_q, open_vote_d;

  logic [15:0]   glovex_q, glovex_d, glovey_q, glovey_d;
  logic          glove_closed_q, glove_closed_d;
  logic          tracked_q, tracked_d;
  logic          pos_valid_q, pos_valid_d;
  logic          first_q, first_d;
  logic [CW-1:0] closed_cnt_q, closed_cnt_d, open_cnt_q, open_cnt_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          tmo_hit;
  logic [TW-1:0] sum_x, sum_y;

  function automatic logic [15:0] smooth(input logic [15:0] cur, input logic [15:0] tgt);
    logic signed [16:0] diff;
    logic signed [16:0] nxt;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    nxt  = $signed({1'b0, cur}) + (diff >>> ALPHA_SHIFT);
    return 16'(nxt);
  endfunction

  // Stage 1: pixel scaling
  always_comb begin
    s1_valid_d = meas_valid;
    prod_x_d   = PW'(meas_x) * PW'(SCALE_X);
    prod_y_d   = PW'(meas_y) * PW'(SCALE_Y);
    area_d     = meas_area;
  end

  // Stage 2: offset and saturate; the offset sits above the fraction bits so no carry crosses them
  always_comb begin
    s2_valid_d    = s1_valid_q;
    sum_x         = TW'((prod_x_q + (PW'(OFFSET_X) << 8)) >> 8);
    sum_y         = TW'((prod_y_q + (PW'(OFFSET_Y) << 8)) >> 8);
    tgt_x_d       = (sum_x > TW'(65535)) ? 16'hFFFF : 16'(sum_x);
    tgt_y_d       = (sum_y > TW'(65535)) ? 16'hFFFF : 16'(sum_y);
    closed_vote_d = area_q < AW'(CLOSE_THRESH);
    open_vote_d   = area_q > AW'(OPEN_THRESH);
  end

  // Stage 3: smoothing, debounce and loss-of-tracking
  always_comb begin
    glovex_d       = glovex_q;
    glovey_d       = glovey_q;
    glove_closed_d = glove_closed_q;
    tracked_d      = tracked_q;
    pos_valid_d    = 1'b0;
    first_d        = first_q;
    closed_cnt_d   = closed_cnt_q;
    open_cnt_d     = open_cnt_q;

    tmo_hit = !meas_valid && (tmo_cnt_q == TMO_W'(TIMEOUT - 1));
    if (meas_valid)                          tmo_cnt_d = '0;
    else if (tmo_cnt_q == TMO_W'(TIMEOUT))   tmo_cnt_d = tmo_cnt_q;
    else                                     tmo_cnt_d = tmo_cnt_q + TMO_W'(1);

    if (s2_valid_q) begin
      if (first_q) begin
        glovex_d = tgt_x_q;
        glovey_d = tgt_y_q;
        first_d  = 1'b0;
      end else begin
        glovex_d = smooth(glovex_q, tgt_x_q);
        glovey_d = smooth(glovey_q, tgt_y_q);
      end
      pos_valid_d = 1'b1;
      tracked_d   = 1'b1;

      if (!closed_vote_q)                        closed_cnt_d = '0;
      else if (closed_cnt_q != CW'(DEBOUNCE))    closed_cnt_d = closed_cnt_q + CW'(1);
      if (!open_vote_q)                          open_cnt_d = '0;
      else if (open_cnt_q != CW'(DEBOUNCE))      open_cnt_d = open_cnt_q + CW'(1);

      if (closed_cnt_d == CW'(DEBOUNCE))         glove_closed_d = 1'b1;
      else if (open_cnt_d == CW'(DEBOUNCE))      glove_closed_d = 1'b0;
    end

    // A lost glove never holds the ball; position is kept for display
    if (tmo_hit) begin
      tracked_d      = 1'b0;
      glove_closed_d = 1'b0;
      closed_cnt_d   = '0;
      open_cnt_d     = '0;
      first_d        = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q     <= 1'b0;
      prod_x_q       <= '0;
      prod_y_q       <= '0;
      area_q         <= '0;
      s2_valid_q     <= 1'b0;
      tgt_x_q        <= '0;
      tgt_y_q        <= '0;
      closed_vote_q  <= 1'b0;
      open_vote_q    <= 1'b0;
      glovex_q       <= '0;
      glovey_q       <= '0;
      glove_closed_q <= 1'b0;
      tracked_q      <= 1'b0;
      pos_valid_q    <= 1'b0;
      first_q        <= 1'b1;
      closed_cnt_q   <= '0;
      open_cnt_q     <= '0;
      tmo_cnt_q      <= '0;
    end else begin
      s1_valid_q     <= s1_valid_d;
      prod_x_q       <= prod_x_d;
      prod_y_q       <= prod_y_d;
      area_q         <= area_d;
      s2_valid_q     <= s2_valid_d;
      tgt_x_q        <= tgt_x_d;
      tgt_y_q        <= tgt_y_d;
      closed_vote_q  <= closed_vote_d;
      open_vote_q    <= open_vote_d;
      glovex_q       <= glovex_d;
      glovey_q       <= glovey_d;
      glove_closed_q <= glove_closed_d;
      tracked_q      <= tracked_d;
      pos_valid_q    <= pos_valid_d;
      first_q        <= first_d;
      closed_cnt_q   <= closed_cnt_d;
      open_cnt_q     <= open_cnt_d;
      tmo_cnt_q      <= tmo_cnt_d;
    end
  end

  assign glovex       = glovex_q;
  assign glovey       = glovey_q;
  assign glove_closed = glove_closed_q;
  assign tracked      = tracked_q;
  assign pos_valid    = pos_valid_q;

endmodule
